// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] DEF_RESET_PC = 16'h0000;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_DONE   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns PC and IR, issues one memory read per fetch_req.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for fetch_req; branches load pc directly
// REQ     | mem_rd asserted at pc, waiting for mem_ack or timeout
// DONE    | IR freshly loaded, instr_valid pulse; may chain next fetch
// HALTED  | fetching stopped, only rst leaves this state
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter int                 TIMEOUT  = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_req,
    input  logic               branch_en,
    input  logic [INSTR_W-1:0] branch_target,
    input  logic               halt,
    output logic               mem_rd,
    output logic [INSTR_W-1:0] mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] pc,
    output logic               busy,
    output logic               halted,
    output logic               fetch_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e       state;
    fetch_state_e       state_nxt;
    logic [INSTR_W-1:0] ir;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               halt_pend;
    logic               timed_out;
    logic               stop_req;

    assign timed_out = (state == ST_REQ) && !mem_ack && (tmo_cnt == TMO_LAST);
    // a halt seen during REQ is held so the in-flight fetch can finish first
    assign stop_req  = halt || halt_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (stop_req) begin
                    state_nxt = ST_HALTED;
                end else if (fetch_req) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_nxt = ST_DONE;
                end else if (timed_out) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (stop_req) begin
                    state_nxt = ST_HALTED;
                end else if (fetch_req) begin
                    state_nxt = ST_REQ;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HALTED: state_nxt = ST_HALTED;
        endcase
    end

    always_comb begin
        mem_rd      = 1'b0;
        busy        = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        unique case (state)
            ST_IDLE:   ;
            ST_REQ: begin
                mem_rd = 1'b1;
                busy   = 1'b1;
            end
            ST_DONE:   instr_valid = 1'b1;
            ST_HALTED: halted = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            ir        <= '0;
            tmo_cnt   <= '0;
            halt_pend <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    tmo_cnt <= '0;
                    if (branch_en && !stop_req) begin
                        pc <= branch_target;
                    end
                end
                ST_REQ: begin
                    if (halt) begin
                        halt_pend <= 1'b1;
                    end
                    // a branch cannot retarget a read already on the bus
                    if (branch_en) begin
                        fetch_err <= 1'b1;
                    end
                    if (mem_ack) begin
                        ir      <= mem_rdata;
                        pc      <= pc + 16'd1;
                        tmo_cnt <= '0;
                    end else if (timed_out) begin
                        fetch_err <= 1'b1;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ST_HALTED: ;
            endcase
        end
    end

    assign mem_addr    = pc;
    assign instruction = ir;

endmodule
